hbm_mvm_wt_fetch_sched: RTL and testbench

//  Sequences HBM weight and quant-scale read commands for one MVM/BN layer.
//  - Walks the layer tile by tile, one tile per CHout/Tout.
//  - Within each tile, walks the CHin scale groups, issuing a weight-burst

---
 rtl/hbm_mvm_wt_fetch_sched.sv | 213 +++++++++++++++++++++
 tb/tb_hbm_mvm_wt_fetch_sched.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbm_mvm_wt_fetch_sched.sv
// -----------------------------------------------------------------------------
// hbm_mvm_wt_fetch_sched
//
// Sequences HBM weight and quant-scale read commands for one MVM/BN layer.
// The layer is walked tile by tile (one tile per CHout/Tout). Within a tile
// every CHin scale group produces a weight burst followed by a scale burst.
// Tiles are throttled by a weight-buffer credit counter, and each tile
// launches one BN-parameter fetch pulse.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               layer start pulse, sampled only while idle
//   cfg_*               layer geometry, latched on the accepted start
//   cmd_valid/ready     valid/ready handshake towards the HBM read engine
//   cmd_addr/len        burst start address and byte length
//   cmd_is_scale        1 = scale burst, 0 = weight burst
//   cmd_last            last command of the current tile
//   tile_release        pulse from compute: one weight slot freed
//   bn_req/bn_tile_idx  1-cycle BN fetch request with its tile index
//   busy                high from accepted start until done
//   done                1-cycle pulse at the end of the layer
// -----------------------------------------------------------------------------
module hbm_mvm_wt_fetch_sched #(
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 24,
    parameter int CNT_W      = 16,
    parameter int MAX_CREDIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_wt_base,
    input  logic [CNT_W-1:0]  cfg_tiles,
    input  logic [CNT_W-1:0]  cfg_groups,
    input  logic [LEN_W-1:0]  cfg_grp_bytes,
    input  logic [LEN_W-1:0]  cfg_last_grp_bytes,
    input  logic [LEN_W-1:0]  cfg_scale_bytes,
    input  logic [ADDR_W-1:0] cfg_tile_stride,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LEN_W-1:0]  cmd_len,
    output logic              cmd_is_scale,
    output logic              cmd_last,
    input  logic              tile_release,
    output logic              bn_req,
    output logic [CNT_W-1:0]  bn_tile_idx,
    output logic              busy,
    output logic              done
);

    localparam int                CRED_W   = $clog2(MAX_CREDIT + 1);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(MAX_CREDIT);
    localparam logic [CRED_W-1:0] CRED_ONE = CRED_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CREDIT,
        S_WT,
        S_SCALE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  tiles_r;
    logic [CNT_W-1:0]  groups_r;
    logic [LEN_W-1:0]  grp_bytes_r;
    logic [LEN_W-1:0]  last_bytes_r;
    logic [LEN_W-1:0]  scale_bytes_r;
    logic [ADDR_W-1:0] tile_stride_r;
    logic [CNT_W-1:0]  t_cnt;
    logic [CNT_W-1:0]  g_cnt;
    logic [ADDR_W-1:0] tile_addr;
    logic [ADDR_W-1:0] grp_addr;
    logic [CRED_W-1:0] credit;

    logic              last_grp;
    logic              next_is_last;
    logic              consume;

    // The last group may be short; a zero last-group length means "full group".
    function automatic logic [LEN_W-1:0] wt_len_of(input logic             is_last,
                                                   input logic [LEN_W-1:0] full_len,
                                                   input logic [LEN_W-1:0] short_len);
        return (is_last && short_len != '0) ? short_len : full_len;
    endfunction

    assign last_grp     = (g_cnt == groups_r - CNT_ONE);
    assign next_is_last = (g_cnt + CNT_ONE == groups_r - CNT_ONE);
    assign consume      = (state == S_CREDIT) && (credit != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            credit       <= CRED_MAX;
            cmd_valid    <= 1'b0;
            cmd_addr     <= '0;
            cmd_len      <= '0;
            cmd_is_scale <= 1'b0;
            cmd_last     <= 1'b0;
            bn_req       <= 1'b0;
            bn_tile_idx  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            t_cnt        <= '0;
            g_cnt        <= '0;
        end else begin
            bn_req <= 1'b0;
            done   <= 1'b0;

            // Credit: a new layer refills the buffer; otherwise release and
            // consume cancel, and a release at full credit is dropped.
            if (state == S_IDLE && start) begin
                credit <= CRED_MAX;
            end else if (consume && !tile_release) begin
                credit <= credit - CRED_ONE;
            end else if (tile_release && !consume && credit != CRED_MAX) begin
                credit <= credit + CRED_ONE;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        tiles_r       <= cfg_tiles;
                        groups_r      <= cfg_groups;
                        grp_bytes_r   <= cfg_grp_bytes;
                        last_bytes_r  <= cfg_last_grp_bytes;
                        scale_bytes_r <= cfg_scale_bytes;
                        tile_stride_r <= cfg_tile_stride;
                        tile_addr     <= cfg_wt_base;
                        grp_addr      <= cfg_wt_base;
                        t_cnt         <= '0;
                        g_cnt         <= '0;
                        if (cfg_tiles == '0 || cfg_groups == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_CREDIT;
                            busy  <= 1'b1;
                        end
                    end
                end

                S_CREDIT: begin
                    if (credit != '0) begin
                        state        <= S_WT;
                        bn_req       <= 1'b1;
                        bn_tile_idx  <= t_cnt;
                        cmd_valid    <= 1'b1;
                        cmd_addr     <= grp_addr;
                        cmd_len      <= wt_len_of(last_grp, grp_bytes_r, last_bytes_r);
                        cmd_is_scale <= 1'b0;
                        cmd_last     <= 1'b0;
                    end
                end

                S_WT: begin
                    if (cmd_ready) begin
                        // Scale block sits directly behind this group's weights.
                        state        <= S_SCALE;
                        cmd_addr     <= cmd_addr + ADDR_W'(cmd_len);
                        cmd_len      <= scale_bytes_r;
                        cmd_is_scale <= 1'b1;
                        cmd_last     <= last_grp;
                    end
                end

                S_SCALE: begin
                    if (cmd_ready) begin
                        if (!last_grp) begin
                            // Next group starts right after this scale block.
                            state        <= S_WT;
                            g_cnt        <= g_cnt + CNT_ONE;
                            grp_addr     <= cmd_addr + ADDR_W'(scale_bytes_r);
                            cmd_addr     <= cmd_addr + ADDR_W'(scale_bytes_r);
                            cmd_len      <= wt_len_of(next_is_last, grp_bytes_r, last_bytes_r);
                            cmd_is_scale <= 1'b0;
                            cmd_last     <= 1'b0;
                        end else begin
                            state     <= S_NEXT;
                            cmd_valid <= 1'b0;
                        end
                    end
                end

                S_NEXT: begin
                    if (t_cnt == tiles_r - CNT_ONE) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state     <= S_CREDIT;
                        t_cnt     <= t_cnt + CNT_ONE;
                        g_cnt     <= '0;
                        tile_addr <= tile_addr + tile_stride_r;
                        grp_addr  <= tile_addr + tile_stride_r;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hbm_mvm_wt_fetch_sched.sv
module tb_hbm_mvm_wt_fetch_sched;

    localparam int ADDR_W     = 32;
    localparam int LEN_W      = 24;
    localparam int CNT_W      = 16;
    localparam int MAX_CREDIT = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [23:0] len;
        logic        sc;
        logic        last;
    } cmd_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] cfg_wt_base = '0;
    logic [CNT_W-1:0]  cfg_tiles = '0;
    logic [CNT_W-1:0]  cfg_groups = '0;
    logic [LEN_W-1:0]  cfg_grp_bytes = '0;
    logic [LEN_W-1:0]  cfg_last_grp_bytes = '0;
    logic [LEN_W-1:0]  cfg_scale_bytes = '0;
    logic [ADDR_W-1:0] cfg_tile_stride = '0;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_is_scale;
    logic              cmd_last;
    logic              tile_release;
    logic              bn_req;
    logic [CNT_W-1:0]  bn_tile_idx;
    logic              busy;
    logic              done;

    hbm_mvm_wt_fetch_sched #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .MAX_CREDIT(MAX_CREDIT)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_wt_base(cfg_wt_base), .cfg_tiles(cfg_tiles), .cfg_groups(cfg_groups),
        .cfg_grp_bytes(cfg_grp_bytes), .cfg_last_grp_bytes(cfg_last_grp_bytes),
        .cfg_scale_bytes(cfg_scale_bytes), .cfg_tile_stride(cfg_tile_stride),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_is_scale(cmd_is_scale), .cmd_last(cmd_last),
        .tile_release(tile_release), .bn_req(bn_req), .bn_tile_idx(bn_tile_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    cmd_t exp_q[$];
    int   bn_q[$];

    logic rdy_rand = 1'b0, rdy_fixed = 1'b1;
    logic rel_rand = 1'b0, rel_force = 1'b0;

    int   hs_cnt = 0, done_cnt = 0;
    logic mon_en = 1'b0;
    int   credit_m = MAX_CREDIT;
    logic rst_p = 1'b1, rel_p = 1'b0, start_p = 1'b0, busy_p = 1'b0, done_p = 1'b0;
    logic stall_p = 1'b0;
    cmd_t prev_cmd = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: the full command list of a layer, straight from the address formula.
    task automatic build_model(input logic [31:0] base, input int tiles, input int groups,
                               input logic [23:0] grp, input logic [23:0] lastb,
                               input logic [23:0] scale, input logic [31:0] stride);
        logic [31:0] ta, off;
        logic [23:0] wl;
        exp_q.delete();
        bn_q.delete();
        for (int t = 0; t < tiles; t++) begin
            ta  = base + stride * 32'(t);
            off = '0;
            if (groups > 0) bn_q.push_back(t);
            for (int g = 0; g < groups; g++) begin
                wl = (g == groups - 1 && lastb != 0) ? lastb : grp;
                exp_q.push_back({ta + off, wl, 1'b0, 1'b0});
                exp_q.push_back({ta + off + 32'(wl), scale, 1'b1, 1'(g == groups - 1)});
                off = off + 32'(wl) + 32'(scale);
            end
        end
    endtask

    // Input driver for ready and release, updated just after each rising edge.
    initial begin
        cmd_ready    = 1'b0;
        tile_release = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cmd_ready    = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
            tile_release = rel_rand ? 1'($urandom_range(0, 3) == 0) : rel_force;
        end
    end

    // Compare process: every cycle, against the queued reference and credit rules.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_p) begin
                credit_m = MAX_CREDIT;
            end else begin
                if (bn_req) begin
                    chk("bn_credit_avail", 64'(credit_m > 0), 64'(1));
                    if (bn_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL bn_unexpected actual_tile=%0d required=none", bn_tile_idx);
                    end else begin
                        chk("bn_tile_idx", 64'(bn_tile_idx), 64'(bn_q.pop_front()));
                    end
                end
                if (start_p && !busy_p && !done_p) credit_m = MAX_CREDIT;
                else if (bn_req && !rel_p) credit_m--;
                else if (rel_p && !bn_req && credit_m < MAX_CREDIT) credit_m++;
            end
            if (!rst_p && stall_p) begin
                chk("stall_valid", 64'(cmd_valid), 64'(1));
                chk("stall_cmd", 64'({cmd_addr, cmd_len, cmd_is_scale, cmd_last}), 64'(prev_cmd));
            end
            if (!rst && cmd_valid && cmd_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL cmd_extra actual_addr=%0h required=none", cmd_addr);
                end else begin
                    chk("cmd", 64'({cmd_addr, cmd_len, cmd_is_scale, cmd_last}),
                        64'(exp_q.pop_front()));
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_drained", 64'(exp_q.size()), 64'(0));
                chk("done_no_bn", 64'(bn_req), 64'(0));
                chk("done_busy_low", 64'(busy), 64'(0));
            end
        end
        rst_p    = rst;
        rel_p    = tile_release;
        start_p  = start;
        busy_p   = busy;
        done_p   = done;
        stall_p  = cmd_valid && !cmd_ready;
        prev_cmd = {cmd_addr, cmd_len, cmd_is_scale, cmd_last};
    end

    task automatic set_cfg(input logic [31:0] base, input int tiles, input int groups,
                           input logic [23:0] grp, input logic [23:0] lastb,
                           input logic [23:0] scale, input logic [31:0] stride);
        cfg_wt_base        = base;
        cfg_tiles          = 16'(tiles);
        cfg_groups         = 16'(groups);
        cfg_grp_bytes      = grp;
        cfg_last_grp_bytes = lastb;
        cfg_scale_bytes    = scale;
        cfg_tile_stride    = stride;
    endtask

    task automatic scramble_cfg();
        set_cfg($urandom, $urandom_range(0, 9), $urandom_range(0, 9), 24'($urandom),
                24'($urandom), 24'($urandom), $urandom);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic pulse_release();
        @(posedge clk); #2 rel_force = 1'b1;
        @(posedge clk); #2 rel_force = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0, input int maxc);
        int n = 0;
        while (done_cnt == d0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(done_cnt - d0), 64'(1));
        chk({name, "_drain"}, 64'(exp_q.size() + bn_q.size()), 64'(0));
    endtask

    task automatic run_layer(input string name, input logic [31:0] base, input int tiles,
                             input int groups, input logic [23:0] grp, input logic [23:0] lastb,
                             input logic [23:0] scale, input logic [31:0] stride, input int maxc);
        int d0;
        build_model(base, tiles, groups, grp, lastb, scale, stride);
        set_cfg(base, tiles, groups, grp, lastb, scale, stride);
        d0 = done_cnt;
        pulse_start();
        scramble_cfg();
        wait_done(name, d0, maxc);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int d0, hs0, k;
        logic [31:0] b, s;
        int ti, gi;
        logic [23:0] gb, lb;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_valid", 64'(cmd_valid), 64'(0));
        chk("rst_bn_req", 64'(bn_req), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_outputs", 64'({cmd_addr, cmd_len}), 64'(0));
        chk("rst_bn_idx", 64'(bn_tile_idx), 64'(0));
        @(posedge clk); #1 rst = 1'b0;
        mon_en = 1'b1;

        // Pin the reference against hand-computed layer 1 and the short-last-group case
        build_model(32'd0, 2, 2, 24'd1024, 24'd0, 24'd32, 32'd2112);
        chk("model_t1_w0", 64'(exp_q[0]), 64'({32'd0,    24'd1024, 1'b0, 1'b0}));
        chk("model_t1_s0", 64'(exp_q[1]), 64'({32'd1024, 24'd32,   1'b1, 1'b0}));
        chk("model_t1_w1", 64'(exp_q[2]), 64'({32'd1056, 24'd1024, 1'b0, 1'b0}));
        chk("model_t1_s1", 64'(exp_q[3]), 64'({32'd2080, 24'd32,   1'b1, 1'b1}));
        chk("model_t1_w2", 64'(exp_q[4]), 64'({32'd2112, 24'd1024, 1'b0, 1'b0}));
        chk("model_t1_s3", 64'(exp_q[7]), 64'({32'd4192, 24'd32,   1'b1, 1'b1}));
        build_model(32'd0, 1, 2, 24'd1024, 24'd512, 24'd32, 32'd2112);
        chk("model_t2_w1", 64'(exp_q[2]), 64'({32'd1056, 24'd512, 1'b0, 1'b0}));
        chk("model_t2_s1", 64'(exp_q[3]), 64'({32'd1568, 24'd32,  1'b1, 1'b1}));

        // Basic layer, ready always high, no release
        run_layer("t1_layer", 32'd0, 2, 2, 24'd1024, 24'd0, 24'd32, 32'd2112, 200);
        // Short last group
        run_layer("t2_short_last", 32'd0, 2, 2, 24'd1024, 24'd512, 24'd32, 32'd2112, 200);

        // Credit stall after two tiles, release resumes the third tile promptly
        build_model(32'h100, 4, 2, 24'd256, 24'd0, 24'd16, 32'd1000);
        set_cfg(32'h100, 4, 2, 24'd256, 24'd0, 24'd16, 32'd1000);
        d0 = done_cnt;
        hs0 = hs_cnt;
        pulse_start();
        repeat (30) @(negedge clk);
        chk("t3_stall_hs", 64'(hs_cnt - hs0), 64'(8));
        chk("t3_stall_valid", 64'(cmd_valid), 64'(0));
        chk("t3_stall_busy", 64'(busy), 64'(1));
        pulse_release();
        k = 0;
        while (!cmd_valid && k < 3) begin
            @(negedge clk);
            k++;
        end
        chk("t3_resume_valid", 64'(cmd_valid), 64'(1));
        chk("t3_resume_addr", 64'(cmd_addr), 64'(32'h100 + 32'd2000));
        chk("t3_resume_is_w", 64'(cmd_is_scale), 64'(0));
        repeat (10) @(posedge clk);
        pulse_release();
        wait_done("t3_layer", d0, 200);

        // Empty layers: done exactly one cycle after start, no commands
        build_model(32'd0, 0, 2, 24'd64, 24'd0, 24'd8, 32'd512);
        set_cfg(32'd0, 0, 2, 24'd64, 24'd0, 24'd8, 32'd512);
        pulse_start();
        @(negedge clk);
        chk("t5_empty_done", 64'(done), 64'(1));
        chk("t5_empty_valid", 64'(cmd_valid), 64'(0));
        @(negedge clk);
        chk("t5_empty_done_once", 64'(done), 64'(0));
        run_layer("t5_zero_groups", 32'd0, 3, 0, 24'd64, 24'd0, 24'd8, 32'd512, 20);

        // Start while busy is ignored
        rdy_rand = 1'b1;
        build_model(32'h4000, 2, 3, 24'd100, 24'd40, 24'd12, 32'd800);
        set_cfg(32'h4000, 2, 3, 24'd100, 24'd40, 24'd12, 32'd800);
        d0 = done_cnt;
        pulse_start();
        scramble_cfg();
        cfg_tiles = 16'd1;
        repeat (4) @(posedge clk);
        pulse_start();
        wait_done("t5_start_busy", d0, 500);
        repeat (3) @(posedge clk);

        // Random ready and release, random geometry including address wrap
        rel_rand = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b  = $urandom;
            s  = $urandom;
            ti = $urandom_range(1, 5);
            gi = $urandom_range(1, 4);
            gb = 24'($urandom_range(1, 4096));
            lb = ($urandom_range(0, 1) == 0) ? 24'd0 : 24'($urandom_range(1, 4096));
            run_layer("t4_random", b, ti, gi, gb, lb, 24'($urandom_range(1, 64)), s, 3000);
        end
        rel_rand = 1'b0;
        rdy_rand = 1'b0;

        // Reset during a scale stall, then a clean replay from tile 0
        rdy_fixed = 1'b0;
        build_model(32'h8000, 2, 2, 24'd64, 24'd0, 24'd8, 32'd256);
        set_cfg(32'h8000, 2, 2, 24'd64, 24'd0, 24'd8, 32'd256);
        pulse_start();
        k = 0;
        while (!cmd_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk); #2 rdy_fixed = 1'b1;
        @(posedge clk); #2 rdy_fixed = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_scale_stall", 64'({cmd_valid, cmd_is_scale}), 64'(2'b11));
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t6_rst_valid", 64'(cmd_valid), 64'(0));
        chk("t6_rst_busy", 64'(busy), 64'(0));
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_no_cmd_after_rst", 64'(cmd_valid), 64'(0));
        rdy_fixed = 1'b1;
        run_layer("t6_replay", 32'h8000, 2, 2, 24'd64, 24'd0, 24'd8, 32'd256, 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
